// File: rtl/score_bcd_arbiter.sv
// Round-robin time-sharing of one binary-to-BCD converter between
// the current-score and high-score requesters.
module score_bcd_arbiter #(
  parameter  int W      = 14,
  parameter  int SETTLE = 2,
  localparam int BW     = W + (W - 4) / 3 + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_score,
  input  logic [W-1:0]  bin_score,
  input  logic          req_hi,
  input  logic [W-1:0]  bin_hi,
  output logic [W-1:0]  conv_bin,
  input  logic [BW-1:0] conv_bcd,
  output logic [BW-1:0] bcd_score,
  output logic [BW-1:0] bcd_hi,
  output logic          done_score,
  output logic          done_hi,
  output logic          busy
);

  typedef enum logic {IDLE, CONV} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_pend_score;
  logic          r_pend_hi;
  logic          r_last;
  logic          r_sel;
  logic [3:0]    r_cnt;
  logic [W-1:0]  r_conv_bin;
  logic [BW-1:0] r_bcd_score;
  logic [BW-1:0] r_bcd_hi;
  logic          r_done_score;
  logic          r_done_hi;
  logic          w_gnt_score;
  logic          w_gnt_hi;
  logic          w_gnt;
  logic          w_capture;

  // r_last/r_sel: 1 = high score, 0 = current score
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_score = 1'b0;
    w_gnt_hi    = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_pend_score && (!r_pend_hi || r_last)) begin
          w_gnt_score = 1'b1;
          w_state_nxt = CONV;
        end else if (r_pend_hi) begin
          w_gnt_hi    = 1'b1;
          w_state_nxt = CONV;
        end
      end
      CONV: begin
        if (r_cnt == 4'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_gnt = w_gnt_score | w_gnt_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_score <= 1'b0;
      r_pend_hi    <= 1'b0;
      r_last       <= 1'b1;
      r_sel        <= 1'b0;
      r_cnt        <= 4'd0;
      r_conv_bin   <= '0;
      r_bcd_score  <= '0;
      r_bcd_hi     <= '0;
      r_done_score <= 1'b0;
      r_done_hi    <= 1'b0;
    end else begin
      // a request on the grant edge keeps the flag for a fresh pass
      r_pend_score <= req_score | (r_pend_score & ~w_gnt_score);
      r_pend_hi    <= req_hi | (r_pend_hi & ~w_gnt_hi);
      r_done_score <= w_capture & ~r_sel;
      r_done_hi    <= w_capture & r_sel;
      if (w_gnt) begin
        r_conv_bin <= w_gnt_hi ? bin_hi : bin_score;
        r_sel      <= w_gnt_hi;
        r_last     <= w_gnt_hi;
        r_cnt      <= CNT_INIT;
      end else if (r_state == CONV && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_capture) begin
        if (r_sel) r_bcd_hi    <= conv_bcd;
        else       r_bcd_score <= conv_bcd;
      end
    end
  end

  assign conv_bin   = r_conv_bin;
  assign bcd_score  = r_bcd_score;
  assign bcd_hi     = r_bcd_hi;
  assign done_score = r_done_score;
  assign done_hi    = r_done_hi;
  assign busy       = (r_state == CONV);

endmodule

// File: tb/tb_score_bcd_arbiter.sv
// Bench for score_bcd_arbiter: vector table, corner sequences,
// randomized traffic vs. a timing/BCD model, and a full-range sweep.
module tb_score_bcd_arbiter;
  localparam int W  = 14;
  localparam int BW = 18;
  localparam int SA = 2;
  localparam int SB = 1;
  localparam int BOUND = 3 * SA + 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          a_req_s, a_req_h, a_done_s, a_done_h, a_busy;
  logic [W-1:0]  a_bin_s, a_bin_h, a_conv_bin;
  logic [BW-1:0] a_conv_bcd, a_bcd_s, a_bcd_h;
  logic          b_req_s, b_req_h, b_done_s, b_done_h, b_busy;
  logic [W-1:0]  b_bin_s, b_bin_h, b_conv_bin;
  logic [BW-1:0] b_conv_bcd, b_bcd_s, b_bcd_h;

  function automatic logic [BW-1:0] to_bcd(input int v);
    logic [23:0] r;
    r = '0;
    for (int d = 0; d < 6; d++) begin
      r[d*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r[BW-1:0];
  endfunction

  assign a_conv_bcd = to_bcd(int'(a_conv_bin));
  assign b_conv_bcd = to_bcd(int'(b_conv_bin));

  score_bcd_arbiter #(.W(W), .SETTLE(SA)) u_a (
    .clk(clk), .rst(rst),
    .req_score(a_req_s), .bin_score(a_bin_s),
    .req_hi(a_req_h), .bin_hi(a_bin_h),
    .conv_bin(a_conv_bin), .conv_bcd(a_conv_bcd),
    .bcd_score(a_bcd_s), .bcd_hi(a_bcd_h),
    .done_score(a_done_s), .done_hi(a_done_h),
    .busy(a_busy)
  );

  score_bcd_arbiter #(.W(W), .SETTLE(SB)) u_b (
    .clk(clk), .rst(rst),
    .req_score(b_req_s), .bin_score(b_bin_s),
    .req_hi(b_req_h), .bin_hi(b_bin_h),
    .conv_bin(b_conv_bin), .conv_bcd(b_conv_bcd),
    .bcd_score(b_bcd_s), .bcd_hi(b_bcd_h),
    .done_score(b_done_s), .done_hi(b_done_h),
    .busy(b_busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [BW-1:0] es = '0;
  logic [BW-1:0] eh = '0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit            hi;
    int            bin;
    logic [BW-1:0] exp;
  } vec_t;

  vec_t tbl[7];

  task automatic conv_a(input bit hi, input int bin,
                        input logic [BW-1:0] exp);
    int lat;
    logic [BW-1:0] oth;
    oth = hi ? es : eh;
    @(negedge clk);
    if (hi) begin a_req_h = 1'b1; a_bin_h = W'(bin); end
    else    begin a_req_s = 1'b1; a_bin_s = W'(bin); end
    @(posedge clk);
    @(negedge clk);
    a_req_s = 1'b0;
    a_req_h = 1'b0;
    lat = 0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        check("grant_bin", 32'(a_conv_bin), 32'(bin));
        check("grant_busy", 32'(a_busy), 32'd1);
      end
      if (hi ? a_done_h : a_done_s) begin
        lat = e;
        break;
      end
    end
    check("latency", 32'(lat), 32'(SA + 1));
    check("bcd", 32'(hi ? a_bcd_h : a_bcd_s), 32'(exp));
    check("other_hold", 32'(hi ? a_bcd_s : a_bcd_h), 32'(oth));
    @(posedge clk); #1;
    check("done_width", 32'(hi ? a_done_h : a_done_s), 32'd0);
    if (hi) eh = exp;
    else    es = exp;
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_conv_bin"}, 32'(a_conv_bin), 32'd0);
    check({tag, "_bcd_s"}, 32'(a_bcd_s), 32'd0);
    check({tag, "_bcd_h"}, 32'(a_bcd_h), 32'd0);
    check({tag, "_done"}, 32'({a_done_s, a_done_h}), 32'd0);
    check({tag, "_busy"}, 32'(a_busy), 32'd0);
  endtask

  initial begin
    int ts, th, got, g;
    bit both;
    int order[$];
    int qs[$];
    int qh[$];
    logic [W-1:0] hs[64];
    logic [W-1:0] hh[64];
    logic [BW-1:0] ps, ph;

    tbl[0] = '{1'b0, 1234,  18'h01234};
    tbl[1] = '{1'b1, 16383, 18'h16383};
    tbl[2] = '{1'b0, 0,     18'h00000};
    tbl[3] = '{1'b0, 16383, 18'h16383};
    tbl[4] = '{1'b1, 42,    18'h00042};
    tbl[5] = '{1'b0, 9999,  18'h09999};
    tbl[6] = '{1'b1, 7,     18'h00007};

    rst = 1'b1;
    a_req_s = 0; a_req_h = 0; a_bin_s = '0; a_bin_h = '0;
    b_req_s = 0; b_req_h = 0; b_bin_s = '0; b_bin_h = '0;
    #2;
    check_zero_a("reset");
    check("reset_b_busy", 32'(b_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) conv_a(tbl[i].hi, tbl[i].bin, tbl[i].exp);

    // simultaneous requests, last grant was hi
    @(negedge clk);
    a_req_s = 1; a_req_h = 1; a_bin_s = W'(42); a_bin_h = W'(16383);
    @(posedge clk);
    @(negedge clk);
    a_req_s = 0; a_req_h = 0;
    ts = -1; th = -1; both = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (a_done_s && a_done_h) both = 1;
      if (a_done_s && ts < 0) ts = e;
      if (a_done_h && th < 0) th = e;
    end
    check("tie_score_first", 32'(ts), 32'(SA + 1));
    check("tie_gap", 32'(th - ts), 32'(SA + 1));
    check("tie_excl", 32'(both), 32'd0);
    check("tie_bcd_s", 32'(a_bcd_s), 32'h00042);
    check("tie_bcd_h", 32'(a_bcd_h), 32'h16383);

    // input change after grant is ignored
    @(negedge clk);
    a_req_s = 1; a_bin_s = W'(100);
    @(posedge clk);
    @(negedge clk);
    a_req_s = 0;
    @(posedge clk);
    @(negedge clk);
    a_bin_s = W'(200);
    got = 0;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk); #1;
      if (a_done_s) begin got = 1; break; end
    end
    check("late_bin_done", 32'(got), 32'd1);
    check("late_bin_bcd", 32'(a_bcd_s), 32'h00100);

    // held req_hi plus one score pulse during the hi conversion
    @(negedge clk);
    a_req_h = 1; a_bin_h = W'(9999);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    a_req_s = 1; a_bin_s = W'(55);
    @(posedge clk);
    @(negedge clk);
    a_req_s = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (a_done_h) order.push_back(1);
      if (a_done_s) order.push_back(0);
    end
    check("rr_count", 32'(order.size() >= 5), 32'd1);
    if (order.size() >= 3) begin
      check("rr_order", 32'({order[0][0], order[1][0], order[2][0]}),
            32'b101);
    end else begin
      check("rr_order_len", 32'(order.size()), 32'd3);
    end
    check("rr_one_score", 32'(order.size() - order.sum()), 32'd1);
    check("rr_bcd_h", 32'(a_bcd_h), 32'h09999);
    check("rr_bcd_s", 32'(a_bcd_s), 32'h00055);
    @(negedge clk);
    a_req_h = 0;
    repeat (10) @(posedge clk);

    // reset two cycles into a conversion
    @(negedge clk);
    a_req_s = 1; a_bin_s = W'(321);
    @(posedge clk);
    @(negedge clk);
    a_req_s = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero_a("midrst");
    @(posedge clk); #1;
    check_zero_a("midrst_edge");
    @(negedge clk);
    rst = 1'b0;
    es = '0; eh = '0;
    @(posedge clk); #1;
    check("midrst_no_done", 32'({a_done_s, a_done_h}), 32'd0);
    conv_a(1'b1, 7, 18'h00007);

    // randomized traffic vs. grant-time sampling model
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ps = '0; ph = '0;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      a_req_s = ($urandom % 4 == 0);
      a_req_h = ($urandom % 3 == 0);
      a_bin_s = W'($urandom);
      a_bin_h = W'($urandom);
      hs[k % 64] = a_bin_s;
      hh[k % 64] = a_bin_h;
      if (a_req_s) qs.push_back(k);
      if (a_req_h) qh.push_back(k);
      @(posedge clk); #1;
      g = k - SA;
      check("rnd_excl", 32'(a_done_s & a_done_h), 32'd0);
      if (a_done_s) begin
        check("rnd_bcd_s", 32'(a_bcd_s), 32'(to_bcd(int'(hs[g % 64]))));
        while (qs.size() > 0 && qs[0] < g) void'(qs.pop_front());
        ps = a_bcd_s;
      end else begin
        check("rnd_hold_s", 32'(a_bcd_s), 32'(ps));
      end
      if (a_done_h) begin
        check("rnd_bcd_h", 32'(a_bcd_h), 32'(to_bcd(int'(hh[g % 64]))));
        while (qh.size() > 0 && qh[0] < g) void'(qh.pop_front());
        ph = a_bcd_h;
      end else begin
        check("rnd_hold_h", 32'(a_bcd_h), 32'(ph));
      end
      if (qs.size() > 0) begin
        check("rnd_wait_s", 32'(k - qs[0] <= BOUND), 32'd1);
        if (k - qs[0] > BOUND) qs.delete();
      end
      if (qh.size() > 0) begin
        check("rnd_wait_h", 32'(k - qh[0] <= BOUND), 32'd1);
        if (k - qh[0] > BOUND) qh.delete();
      end
    end
    @(negedge clk);
    a_req_s = 0; a_req_h = 0;

    // full-range sweep on the SETTLE=1 instance
    for (int v = 0; v < 16384; v++) begin
      @(negedge clk);
      b_bin_s = W'(v);
      b_req_s = 1;
      @(posedge clk); #1;
      check("sweep_width", 32'(b_done_s), 32'd0);
      @(negedge clk);
      b_req_s = 0;
      got = 0;
      for (int e = 0; e < 6; e++) begin
        @(posedge clk); #1;
        if (b_done_s) begin got = 1; break; end
      end
      check("sweep_done", 32'(got), 32'd1);
      check("sweep_bcd", 32'(b_bcd_s), 32'(to_bcd(v)));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/score_bcd_arbiter.md
Name: score_bcd_arbiter

Overview:
- Time-shares one combinational binary-to-BCD converter between two scoreboard requesters: current score and high score.
- Captures each request as a pending flag and grants the converter round-robin.
- Drives the converter input and holds it stable for a programmable settle window, since the converter is a long combinational path.
- Latches the converter result into a per-requester BCD register and pulses a per-requester done strobe.

Parameters:
- W, 14, binary score width; must match the converter's W.
- BW, W+(W-4)/3+1 (18 at default), BCD width; derived, not overridden.
- SETTLE, 2, cycles conv_bin is held before capture; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_score  in  1  conversion request for score; pulse or level
- bin_score  in  W  binary score
- req_hi  in  1  conversion request for high score
- bin_hi  in  W  binary high score
- conv_bin  out  W  registered drive to the shared converter input
- conv_bcd  in  BW  shared converter output
- bcd_score  out  BW  latched BCD of score
- bcd_hi  out  BW  latched BCD of high score
- done_score  out  1  one-cycle strobe: bcd_score updated
- done_hi  out  1  one-cycle strobe: bcd_hi updated
- busy  out  1  high while state is CONV

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; pend_score=pend_hi=0; last=HI, so score wins the first tie.
  - conv_bin=0, bcd_score=bcd_hi=0, done_*=0, busy=0, cnt=0.
- Pending flags:
  - Each edge, req_x=1 sets pend_x.
  - Granting x clears pend_x, unless req_x=1 on that same edge; then pend_x stays set and a fresh conversion follows.
  - Multiple req pulses while pending collapse into one conversion.
- FSM states: IDLE, CONV.
- IDLE, no pending flag: stay in IDLE.
- IDLE, exactly one pending: grant it.
- IDLE, both pending: grant the requester != last.
- On a grant edge:
  - conv_bin <= bin_x sampled at this edge; later bin_x changes are ignored.
  - sel <= x; last <= x; cnt <= SETTLE-1; state <= CONV.
- CONV, cnt != 0: cnt decrements; conv_bin held constant.
- CONV, cnt == 0:
  - bcd_sel <= conv_bcd; done_sel <= 1 for exactly one cycle; state <= IDLE.
  - The other requester's bcd register is unchanged.
- Latency: grant at edge E0 → capture at edge E(SETTLE) → done high during the cycle after E(SETTLE).
- Back-to-back: the first IDLE cycle after capture can grant again, so the conversion period is SETTLE+1 cycles.
- busy = (state==CONV); registered.
- done_score and done_hi are never high in the same cycle.
- Requests arriving during CONV only set pending flags; the conversion in flight is never aborted.
- Reset asserted mid-CONV: immediately returns all outputs to reset values and discards pending flags and the partial conversion.
- Arithmetic: no arithmetic on data; conv_bcd is copied unmodified.
  - Full-scale input 2^W-1 must pass through. At W=14: 16383 → 0x16383, using the top digit bit.

Test Plan:
- Reset, then req_score pulse with bin_score=1234 and SETTLE=2 → conv_bin=1234 after grant edge; done_score pulses 3 cycles after the req edge; bcd_score=0x01234; bcd_hi stays 0.
- req_score and req_hi on the same edge, bin_score=42, bin_hi=16383 → score converts first, done_score with bcd_score=0x00042; hi granted the next IDLE cycle, done_hi with bcd_hi=0x16383; the two dones are SETTLE+1 cycles apart.
- Change bin_score from 100 to 200 one cycle after its grant → bcd_score=0x00100, not 0x00200.
- Hold req_hi high continuously with bin_hi=9999 and also pulse req_score → grants alternate hi/score; hi is never starved; bcd_hi=0x09999.
- Assert rst two cycles into a CONV → all outputs 0 immediately, no done pulse; after release, a new req_hi with bin_hi=7 produces bcd_hi=0x00007.
- Sweep bin_score 0..16383 with SETTLE=1 against a reference model → every bcd_score matches the model; each done_score is exactly one cycle wide.
